i_type_arbiter: RTL and testbench

Shares one I-type immediate ALU between two issue requesters (req0, req1) using round-robin arbitration. Each requester presents an operation under a valid/ready handshake. The granted operation is executed combinationally by the shared I-type ALU, and the result is captured into a single-entry writeback register. That register drives the register-file writeback port under its own valid/ready handshake, so backpressure from writeback stalls both requesters.

---
 rtl/i_type_arbiter.sv | 123 ++++++++++++
 tb/tb_i_type_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/i_type_arbiter.sv
// Round-robin sharing of one RV32 I-type immediate ALU between two requesters,
// with a single-entry registered writeback stage under valid/ready.

module i_type_alu #(
   parameter int XLEN = 32
) (
   input  logic [6:0]      opcode,
   input  logic [2:0]      funct3,
   input  logic [11:0]     imm,
   input  logic [XLEN-1:0] rs1,
   output logic [XLEN-1:0] result
);
   logic [XLEN-1:0] imm_sx;
   logic [4:0]      shamt;

   assign imm_sx = {{(XLEN-12){imm[11]}}, imm};
   assign shamt  = imm[4:0];

   always_comb begin
      result = '0;
      if (opcode == 7'b0010011) begin
         case (funct3)
            3'b000: result = rs1 + imm_sx;
            3'b010: result = {{(XLEN-1){1'b0}}, ($signed(rs1) < $signed(imm_sx))};
            3'b011: result = {{(XLEN-1){1'b0}}, (rs1 < imm_sx)};
            3'b100: result = rs1 ^ imm_sx;
            3'b110: result = rs1 | imm_sx;
            3'b111: result = rs1 & imm_sx;
            3'b001: result = rs1 << shamt;
            3'b101: result = imm[10] ? XLEN'($signed(rs1) >>> shamt) : (rs1 >> shamt);
            default: result = '0;
         endcase
      end
   end
endmodule

// state | meaning
// EMPTY | writeback register holds nothing, wb_valid=0
// FULL  | writeback register holds a result, wb_valid=1
module i_type_arbiter #(
   parameter int RD_W = 5,
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req0_valid,
   output logic            req0_ready,
   input  logic [2:0]      req0_funct3,
   input  logic [11:0]     req0_imm,
   input  logic [XLEN-1:0] req0_rs1,
   input  logic [RD_W-1:0] req0_rd,
   input  logic            req1_valid,
   output logic            req1_ready,
   input  logic [2:0]      req1_funct3,
   input  logic [11:0]     req1_imm,
   input  logic [XLEN-1:0] req1_rs1,
   input  logic [RD_W-1:0] req1_rd,
   output logic            wb_valid,
   input  logic            wb_ready,
   output logic [XLEN-1:0] wb_data,
   output logic [RD_W-1:0] wb_rd,
   output logic            wb_src
);
   typedef enum logic {EMPTY, FULL} wb_state_t;

   wb_state_t       state, state_next;
   logic            last;
   logic            grant;
   logic            grant_any;
   logic            can_accept;
   logic            accept;
   logic [2:0]      alu_funct3;
   logic [11:0]     alu_imm;
   logic [XLEN-1:0] alu_rs1;
   logic [XLEN-1:0] alu_result;

   assign wb_valid = (state == FULL);

   always_comb begin
      state_next = state;
      grant_any  = req0_valid || req1_valid;
      // On a tie the requester not served last wins; otherwise the sole valid one.
      grant      = (req0_valid && req1_valid) ? !last : req1_valid;
      can_accept = !wb_valid || wb_ready;
      accept     = !rst && can_accept && grant_any;
      req0_ready = accept && !grant;
      req1_ready = accept && grant;
      if (accept)
         state_next = FULL;
      else if (state == FULL && wb_ready)
         state_next = EMPTY;
   end

   assign alu_funct3 = grant ? req1_funct3 : req0_funct3;
   assign alu_imm    = grant ? req1_imm    : req0_imm;
   assign alu_rs1    = grant ? req1_rs1    : req0_rs1;

   i_type_alu #(.XLEN(XLEN)) u_alu (
      .opcode (7'b0010011),
      .funct3 (alu_funct3),
      .imm    (alu_imm),
      .rs1    (alu_rs1),
      .result (alu_result)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= EMPTY;
         wb_data <= '0;
         wb_rd   <= '0;
         wb_src  <= 1'b0;
         last    <= 1'b1;
      end else begin
         state <= state_next;
         if (accept) begin
            wb_data <= alu_result;
            wb_rd   <= grant ? req1_rd : req0_rd;
            wb_src  <= grant;
            last    <= grant;
         end
      end
   end
endmodule

// File: tb/tb_i_type_arbiter.sv
// Scoreboard bench for i_type_arbiter: driver predicts grants and pushes
// hand-computed results; a monitor pops and checks on every writeback drain.

module tb_i_type_arbiter;
   logic        clk = 1'b0;
   logic        rst;
   logic        req0_valid, req1_valid;
   logic        req0_ready, req1_ready;
   logic [2:0]  req0_funct3, req1_funct3;
   logic [11:0] req0_imm, req1_imm;
   logic [31:0] req0_rs1, req1_rs1;
   logic [4:0]  req0_rd, req1_rd;
   logic        wb_valid, wb_ready, wb_src;
   logic [31:0] wb_data;
   logic [4:0]  wb_rd;

   i_type_arbiter #(.RD_W(5), .XLEN(32)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_funct3(req0_funct3),
      .req0_imm(req0_imm), .req0_rs1(req0_rs1), .req0_rd(req0_rd),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_funct3(req1_funct3),
      .req1_imm(req1_imm), .req1_rs1(req1_rs1), .req1_rd(req1_rd),
      .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data),
      .wb_rd(wb_rd), .wb_src(wb_src)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0]  f3;
      logic [11:0] imm;
      logic [31:0] rs1;
      logic [4:0]  rd;
      logic [31:0] res;
   } op_t;

   typedef struct packed {
      logic [31:0] d;
      logic [4:0]  rd;
      logic        src;
   } exp_t;

   op_t  tab0[8];
   op_t  tab1[8];
   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_err = 0;
   int   p0 = 0, p1 = 0;
   int   w0 = 0, w1 = 0;
   logic m_full, m_last;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: actual=%h required=%h at %0t", name, act, req, $time);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (!rst && wb_valid && wb_ready) begin
         if (exp_q.size() == 0) begin
            chk("drain_with_empty_scoreboard", 32'd1, 32'd0);
         end else begin
            e = exp_q.pop_front();
            chk("wb_data", wb_data, e.d);
            chk("wb_rd", {27'd0, wb_rd}, {27'd0, e.rd});
            chk("wb_src", {31'd0, wb_src}, {31'd0, e.src});
         end
      end
   end

   task automatic drive(input logic v0, input logic v1, input logic wr);
      req0_valid  = v0;
      req1_valid  = v1;
      wb_ready    = wr;
      req0_funct3 = tab0[p0 % 8].f3;
      req0_imm    = tab0[p0 % 8].imm;
      req0_rs1    = tab0[p0 % 8].rs1;
      req0_rd     = tab0[p0 % 8].rd;
      req1_funct3 = tab1[p1 % 8].f3;
      req1_imm    = tab1[p1 % 8].imm;
      req1_rs1    = tab1[p1 % 8].rs1;
      req1_rd     = tab1[p1 % 8].rd;
   endtask

   // One cycle: inputs applied after posedge, prediction and checks at negedge.
   task automatic step(input logic v0, input logic v1, input logic wr);
      logic can, g, acc;
      exp_t e;
      drive(v0, v1, wr);
      @(negedge clk);
      can = !m_full || wr;
      g   = (v0 && v1) ? !m_last : v1;
      acc = can && (v0 || v1);
      chk("wb_valid", {31'd0, wb_valid}, {31'd0, m_full});
      chk("req0_ready", {31'd0, req0_ready}, {31'd0, acc && !g});
      chk("req1_ready", {31'd0, req1_ready}, {31'd0, acc && g});
      if (m_full && !wr && exp_q.size() > 0) begin
         e = exp_q[exp_q.size()-1];
         chk("stall_wb_data", wb_data, e.d);
         chk("stall_wb_src", {31'd0, wb_src}, {31'd0, e.src});
      end
      if (v0 && !req0_ready && req1_ready) w0++;
      if (!v0 || req0_ready) w0 = 0;
      if (v1 && !req1_ready && req0_ready) w1++;
      if (!v1 || req1_ready) w1 = 0;
      chk("wait0_bound", {31'd0, w0 > 1}, 32'd0);
      chk("wait1_bound", {31'd0, w1 > 1}, 32'd0);
      if (acc) begin
         if (g) begin
            e = '{tab1[p1 % 8].res, tab1[p1 % 8].rd, 1'b1};
            p1++;
         end else begin
            e = '{tab0[p0 % 8].res, tab0[p0 % 8].rd, 1'b0};
            p0++;
         end
         exp_q.push_back(e);
         m_full = 1'b1;
         m_last = g;
      end else if (m_full && wr) begin
         m_full = 1'b0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input logic v0, input logic v1);
      drive(v0, v1, 1'b1);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_req0_ready", {31'd0, req0_ready}, 32'd0);
      chk("rst_req1_ready", {31'd0, req1_ready}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
      chk("rst_wb_data", wb_data, 32'd0);
      chk("rst_wb_rd", {27'd0, wb_rd}, 32'd0);
      chk("rst_wb_src", {31'd0, wb_src}, 32'd0);
      m_full = 1'b0;
      m_last = 1'b1;
      w0 = 0;
      w1 = 0;
      exp_q.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      //            f3      imm      rs1           rd     result
      tab0[0] = '{3'b000, 12'hFFF, 32'h0000_0010, 5'd3,  32'h0000_000F}; // ADDI
      tab0[1] = '{3'b110, 12'h0F0, 32'h0000_1200, 5'd4,  32'h0000_12F0}; // ORI
      tab0[2] = '{3'b110, 12'h800, 32'h0000_0001, 5'd5,  32'hFFFF_F801}; // ORI
      tab0[3] = '{3'b111, 12'h0FF, 32'h1234_5678, 5'd6,  32'h0000_0078}; // ANDI
      tab0[4] = '{3'b001, 12'h004, 32'h0000_00F1, 5'd7,  32'h0000_0F10}; // SLLI
      tab0[5] = '{3'b011, 12'hFFF, 32'h0000_0005, 5'd8,  32'h0000_0001}; // SLTIU
      tab0[6] = '{3'b101, 12'h004, 32'h8000_0000, 5'd9,  32'h0800_0000}; // SRLI
      tab0[7] = '{3'b000, 12'h001, 32'hFFFF_FFFF, 5'd10, 32'h0000_0000}; // ADDI
      tab1[0] = '{3'b100, 12'h0FF, 32'h0000_0F0F, 5'd11, 32'h0000_0FF0}; // XORI
      tab1[1] = '{3'b100, 12'hFFF, 32'h1234_5678, 5'd12, 32'hEDCB_A987}; // XORI
      tab1[2] = '{3'b101, 12'h403, 32'h8000_0000, 5'd13, 32'hF000_0000}; // SRAI
      tab1[3] = '{3'b010, 12'hFFF, 32'h0000_0000, 5'd14, 32'h0000_0000}; // SLTI
      tab1[4] = '{3'b010, 12'h001, 32'hFFFF_FFFF, 5'd15, 32'h0000_0001}; // SLTI
      tab1[5] = '{3'b000, 12'h7FF, 32'h0000_0001, 5'd16, 32'h0000_0800}; // ADDI
      tab1[6] = '{3'b011, 12'h001, 32'h0000_0000, 5'd17, 32'h0000_0001}; // SLTIU
      tab1[7] = '{3'b100, 12'h800, 32'h0000_0000, 5'd18, 32'hFFFF_F800}; // XORI

      @(posedge clk);
      #1;
      do_reset(1'b0, 1'b0);

      // ADDI from req0, visible one cycle later, consumed the cycle after
      step(1, 0, 1);
      chk("addi_wb_valid", {31'd0, wb_valid}, 32'd1);
      chk("addi_wb_data", wb_data, 32'h0000_000F);
      step(0, 0, 1);

      // tie alternation starting with req0 after reset
      do_reset(1'b0, 1'b0);
      for (int i = 0; i < 4; i++) step(1, 1, 1);

      // stall with both valid, then drain and accept on the same edge
      for (int i = 0; i < 4; i++) step(1, 1, 0);
      step(1, 1, 1);
      chk("drain_accept_wb_valid", {31'd0, wb_valid}, 32'd1);

      // SRAI and SLTI from req1
      step(0, 1, 1);
      chk("srai_wb_data", wb_data, 32'hF000_0000);
      step(0, 1, 1);
      chk("slti_wb_data", wb_data, 32'h0000_0000);
      step(0, 0, 1);

      // reset while FULL with a requester valid
      step(1, 0, 0);
      do_reset(1'b1, 1'b0);
      step(1, 1, 1);
      chk("post_reset_src", {31'd0, wb_src}, 32'd0);

      // random valid and backpressure patterns
      for (int i = 0; i < 300; i++)
         step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      step(0, 0, 1);
      step(0, 0, 1);
      chk("scoreboard_empty", exp_q.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
